// File: rtl/alarm_ringer_pkg.sv
// Shared constants and types for the alarm ringer: disabled-hour marker,
// FSM state codes and the display digit codes used by the display wrappers.
package alarm_ringer_pkg;

  localparam logic [4:0] ALARM_DISABLED_HOUR = 5'd24;

  localparam logic [3:0] DIGIT_BLANK = 4'hf;
  localparam logic [3:0] DIGIT_DASH  = 4'he;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alarm_ringer_if.sv
// Time and alarm bus: timekeeping supplies the current time and 1 Hz tick,
// the alarm setter supplies the stored alarm time.
interface alarm_ringer_if;
  logic       tick_1hz;
  logic [4:0] cur_hours;
  logic [5:0] cur_minutes;
  logic [5:0] cur_seconds;
  logic [4:0] alarm_hours;
  logic [5:0] alarm_minutes;

  modport master (
    output tick_1hz, cur_hours, cur_minutes, cur_seconds,
    output alarm_hours, alarm_minutes
  );

  modport slave (
    input tick_1hz, cur_hours, cur_minutes, cur_seconds,
    input alarm_hours, alarm_minutes
  );
endinterface

// File: rtl/alarm_ringer_tick_counter.sv
// Tick-enabled seconds counter with synchronous clear; done flags the tick
// that lands on the terminal count.
module tick_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         tick,
  input  logic [W-1:0] terminal,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (tick) begin
      count <= count + W'(1);
    end
  end

  assign done = tick && (count == terminal);

endmodule

// File: rtl/alarm_ringer.sv
// Alarm ringer: compares running time against the stored alarm and drives
// the buzzer, with bounded snooze, dismiss and ring auto-timeout.
//
// state      | meaning
// ST_IDLE    | waiting for the alarm minute; seconds counter held clear
// ST_RINGING | buzzer active; counting toward ring timeout
// ST_SNOOZE  | silenced; counting toward re-ring
module alarm_ringer
  import alarm_ringer_pkg::*;
#(
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_S       = 300,
  parameter int MAX_SNOOZES    = 3
) (
  input  logic          clk,
  input  logic          reset,
  alarm_ringer_if.slave bus,
  input  logic          snooze,
  input  logic          dismiss,
  input  logic          real_quarter,
  output logic          ringing,
  output logic          snoozing,
  output logic          buzzer,
  output logic          missed,
  output logic [1:0]    state
);

  localparam int SEC_W = $clog2(max_int(RING_TIMEOUT_S, SNOOZE_S));
  localparam int SNZ_W = $clog2(MAX_SNOOZES + 1);

  localparam logic [SEC_W-1:0] RING_LAST   = SEC_W'(RING_TIMEOUT_S - 1);
  localparam logic [SEC_W-1:0] SNOOZE_LAST = SEC_W'(SNOOZE_S - 1);
  localparam logic [SNZ_W-1:0] SNZ_MAX     = SNZ_W'(MAX_SNOOZES);

  state_t           state_r, state_next;
  logic             missed_r, missed_next;
  logic [SNZ_W-1:0] snz_cnt_r, snz_cnt_next;
  logic             sec_clear;
  logic             sec_done;
  logic [SEC_W-1:0] sec_terminal;
  logic             alarm_off;
  logic             match;

  assign alarm_off = (bus.alarm_hours == ALARM_DISABLED_HOUR);
  assign match     = bus.tick_1hz && !alarm_off
                     && (bus.cur_hours == bus.alarm_hours)
                     && (bus.cur_minutes == bus.alarm_minutes)
                     && (bus.cur_seconds == 6'd0);

  // One counter serves both windows; the terminal follows the current state.
  assign sec_terminal = (state_r == ST_SNOOZE) ? SNOOZE_LAST : RING_LAST;

  tick_counter #(.W(SEC_W)) u_sec_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (sec_clear),
    .tick     (bus.tick_1hz),
    .terminal (sec_terminal),
    .done     (sec_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      missed_r  <= 1'b0;
      snz_cnt_r <= '0;
    end else begin
      state_r   <= state_next;
      missed_r  <= missed_next;
      snz_cnt_r <= snz_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_r;
    missed_next  = missed_r;
    snz_cnt_next = snz_cnt_r;
    sec_clear    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        sec_clear = 1'b1;
        if (match) begin
          state_next   = ST_RINGING;
          missed_next  = 1'b0;
          snz_cnt_next = '0;
        end else if (dismiss) begin
          missed_next = 1'b0;
        end
      end
      ST_RINGING: begin
        if (alarm_off || dismiss) begin
          state_next = ST_IDLE;
        end else if (sec_done) begin
          state_next  = ST_IDLE;
          missed_next = 1'b1;
        end else if (snooze && (snz_cnt_r < SNZ_MAX)) begin
          state_next   = ST_SNOOZE;
          snz_cnt_next = snz_cnt_r + SNZ_W'(1);
          sec_clear    = 1'b1;
        end
      end
      ST_SNOOZE: begin
        if (alarm_off || dismiss) begin
          state_next = ST_IDLE;
        end else if (sec_done) begin
          state_next = ST_RINGING;
          sec_clear  = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        sec_clear  = 1'b1;
      end
    endcase
  end

  assign state    = state_r;
  assign ringing  = (state_r == ST_RINGING);
  assign snoozing = (state_r == ST_SNOOZE);
  assign missed   = missed_r;
  assign buzzer   = ringing & real_quarter;

endmodule

// File: tb/tb_alarm_ringer.sv
// Self-checking bench for alarm_ringer with RING_TIMEOUT_S=5, SNOOZE_S=3, MAX_SNOOZES=2.
module tb_alarm_ringer;
  import alarm_ringer_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       snooze = 1'b0;
  logic       dismiss = 1'b0;
  logic       real_quarter = 1'b1;
  logic       ringing, snoozing, buzzer, missed;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         rst;
    bit         tk;
    logic [5:0] sec;
    bit         sz;
    bit         ds;
    logic [4:0] ah;
    logic [5:0] am;
    logic [1:0] st;
    logic       ms;
  } vec_t;

  typedef struct {
    logic [1:0] st;
    logic       ms;
  } exp_t;

  exp_t sb[$];
  int   ring_sb[$];

  alarm_ringer_if bus();

  alarm_ringer #(.RING_TIMEOUT_S(5), .SNOOZE_S(3), .MAX_SNOOZES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .snooze       (snooze),
    .dismiss      (dismiss),
    .real_quarter (real_quarter),
    .ringing      (ringing),
    .snoozing     (snoozing),
    .buzzer       (buzzer),
    .missed       (missed),
    .state        (state)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(bit tk, int sec, bit sz, bit ds, int st, bit ms);
    vec_t x;
    x.rst = 1'b0; x.tk = tk; x.sec = 6'(sec); x.sz = sz; x.ds = ds;
    x.ah = 5'd7; x.am = 6'd30; x.st = 2'(st); x.ms = ms;
    return x;
  endfunction

  task automatic step(input vec_t x);
    reset = x.rst;
    bus.alarm_hours = x.ah; bus.alarm_minutes = x.am;
    bus.tick_1hz = x.tk;
    bus.cur_hours = 5'd7; bus.cur_minutes = 6'd30; bus.cur_seconds = x.sec;
    snooze = x.sz; dismiss = x.ds;
    @(posedge clk); #1;
    reset = 1'b0; bus.tick_1hz = 1'b0; snooze = 1'b0; dismiss = 1'b0;
  endtask

  task automatic tick_at(input int h, input int m, input int s);
    bus.cur_hours = 5'(h); bus.cur_minutes = 6'(m); bus.cur_seconds = 6'(s);
    bus.tick_1hz = 1'b1;
    @(posedge clk); #1;
    bus.tick_1hz = 1'b0;
  endtask

  task automatic test_reset();
    vec_t v[$];
    vec_t x;
    exp_t e;
    x = mk(0, 7, 0, 0, 0, 0); x.rst = 1'b1;
    v.push_back(x); v.push_back(x);
    v.push_back(mk(0, 7, 0, 0, 0, 0));
    foreach (v[i]) begin
      sb.push_back('{st: v[i].st, ms: v[i].ms});
      step(v[i]);
      e = sb.pop_front();
      checks++;
      if (state !== e.st || missed !== e.ms || ringing !== (e.st == 2'd1) ||
          snoozing !== (e.st == 2'd2) || buzzer !== (e.st == 2'd1)) begin
        errors++;
        $display("FAIL reset[%0d]: got state=%0d missed=%b ringing=%b snoozing=%b buzzer=%b, expected state=%0d missed=%b",
                 i, state, missed, ringing, snoozing, buzzer, e.st, e.ms);
      end
    end
  endtask

  task automatic test_match();
    vec_t v[$];
    vec_t x;
    exp_t e;
    v.push_back(mk(1, 1, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0));
    x = mk(1, 0, 0, 0, 0, 0); x.ah = 5'd24; v.push_back(x);
    x = mk(1, 0, 0, 0, 0, 0); x.am = 6'd31; v.push_back(x);
    v.push_back(mk(1, 0, 0, 0, 1, 0));
    foreach (v[i]) begin
      sb.push_back('{st: v[i].st, ms: v[i].ms});
      step(v[i]);
      e = sb.pop_front();
      checks++;
      if (state !== e.st || missed !== e.ms || ringing !== (e.st == 2'd1) ||
          snoozing !== (e.st == 2'd2) || buzzer !== (e.st == 2'd1)) begin
        errors++;
        $display("FAIL match[%0d]: got state=%0d missed=%b ringing=%b snoozing=%b buzzer=%b, expected state=%0d missed=%b",
                 i, state, missed, ringing, snoozing, buzzer, e.st, e.ms);
      end
    end
    real_quarter = 1'b0; #1;
    checks++;
    if (buzzer !== 1'b0) begin
      errors++;
      $display("FAIL buzzer_low: got buzzer=%b, expected 0", buzzer);
    end
    real_quarter = 1'b1; #1;
    checks++;
    if (buzzer !== 1'b1) begin
      errors++;
      $display("FAIL buzzer_high: got buzzer=%b, expected 1", buzzer);
    end
  endtask

  task automatic test_timeout();
    vec_t v[$];
    exp_t e;
    v.push_back(mk(0, 7, 0, 1, 0, 0));
    v.push_back(mk(1, 0, 0, 0, 1, 0));
    for (int k = 0; k < 4; k++) v.push_back(mk(1, 7, 0, 0, 1, 0));
    v.push_back(mk(1, 7, 0, 0, 0, 1));
    v.push_back(mk(0, 7, 0, 0, 0, 1));
    v.push_back(mk(0, 7, 1, 0, 0, 1));
    v.push_back(mk(0, 7, 0, 1, 0, 0));
    foreach (v[i]) begin
      sb.push_back('{st: v[i].st, ms: v[i].ms});
      step(v[i]);
      e = sb.pop_front();
      checks++;
      if (state !== e.st || missed !== e.ms || ringing !== (e.st == 2'd1) ||
          snoozing !== (e.st == 2'd2) || buzzer !== (e.st == 2'd1)) begin
        errors++;
        $display("FAIL timeout[%0d]: got state=%0d missed=%b ringing=%b snoozing=%b buzzer=%b, expected state=%0d missed=%b",
                 i, state, missed, ringing, snoozing, buzzer, e.st, e.ms);
      end
    end
  endtask

  task automatic test_snooze();
    vec_t v[$];
    exp_t e;
    v.push_back(mk(1, 0, 0, 0, 1, 0));
    for (int r = 0; r < 2; r++) begin
      v.push_back(mk(0, 7, 1, 0, 2, 0));
      v.push_back(mk(1, 7, 0, 0, 2, 0));
      v.push_back(mk(1, 7, 0, 0, 2, 0));
      v.push_back(mk(1, 7, 0, 0, 1, 0));
    end
    v.push_back(mk(0, 7, 1, 0, 1, 0));
    for (int k = 0; k < 4; k++) v.push_back(mk(1, 7, 0, 0, 1, 0));
    v.push_back(mk(0, 7, 0, 1, 0, 0));
    foreach (v[i]) begin
      sb.push_back('{st: v[i].st, ms: v[i].ms});
      step(v[i]);
      e = sb.pop_front();
      checks++;
      if (state !== e.st || missed !== e.ms || ringing !== (e.st == 2'd1) ||
          snoozing !== (e.st == 2'd2) || buzzer !== (e.st == 2'd1)) begin
        errors++;
        $display("FAIL snooze[%0d]: got state=%0d missed=%b ringing=%b snoozing=%b buzzer=%b, expected state=%0d missed=%b",
                 i, state, missed, ringing, snoozing, buzzer, e.st, e.ms);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[$];
    exp_t e;
    v.push_back(mk(1, 0, 0, 0, 1, 0));
    for (int k = 0; k < 4; k++) v.push_back(mk(1, 7, 0, 0, 1, 0));
    v.push_back(mk(1, 7, 0, 1, 0, 0));
    v.push_back(mk(1, 0, 0, 0, 1, 0));
    v.push_back(mk(0, 7, 1, 1, 0, 0));
    v.push_back(mk(1, 0, 0, 0, 1, 0));
    for (int k = 0; k < 4; k++) v.push_back(mk(1, 7, 0, 0, 1, 0));
    v.push_back(mk(1, 7, 1, 0, 0, 1));
    v.push_back(mk(0, 7, 0, 1, 0, 0));
    foreach (v[i]) begin
      sb.push_back('{st: v[i].st, ms: v[i].ms});
      step(v[i]);
      e = sb.pop_front();
      checks++;
      if (state !== e.st || missed !== e.ms || ringing !== (e.st == 2'd1) ||
          snoozing !== (e.st == 2'd2) || buzzer !== (e.st == 2'd1)) begin
        errors++;
        $display("FAIL coincide[%0d]: got state=%0d missed=%b ringing=%b snoozing=%b buzzer=%b, expected state=%0d missed=%b",
                 i, state, missed, ringing, snoozing, buzzer, e.st, e.ms);
      end
    end
  endtask

  task automatic test_disable();
    vec_t v[$];
    vec_t x;
    exp_t e;
    v.push_back(mk(1, 0, 0, 0, 1, 0));
    v.push_back(mk(0, 7, 1, 0, 2, 0));
    x = mk(1, 7, 0, 0, 2, 0); x.am = 6'd45; v.push_back(x); v.push_back(x);
    x = mk(1, 7, 0, 0, 1, 0); x.am = 6'd45; v.push_back(x);
    v.push_back(mk(0, 7, 1, 0, 2, 0));
    x = mk(0, 7, 0, 0, 0, 0); x.ah = 5'd24; v.push_back(x);
    v.push_back(mk(1, 0, 0, 0, 1, 0));
    x = mk(0, 7, 0, 0, 0, 0); x.ah = 5'd24; v.push_back(x);
    v.push_back(mk(1, 0, 0, 0, 1, 0));
    x = mk(0, 7, 0, 0, 0, 0); x.rst = 1'b1; v.push_back(x);
    v.push_back(mk(1, 0, 0, 0, 1, 0));
    for (int k = 0; k < 4; k++) v.push_back(mk(1, 7, 0, 0, 1, 0));
    v.push_back(mk(1, 7, 0, 0, 0, 1));
    x = mk(0, 7, 0, 0, 0, 0); x.rst = 1'b1; v.push_back(x);
    foreach (v[i]) begin
      sb.push_back('{st: v[i].st, ms: v[i].ms});
      step(v[i]);
      e = sb.pop_front();
      checks++;
      if (state !== e.st || missed !== e.ms || ringing !== (e.st == 2'd1) ||
          snoozing !== (e.st == 2'd2) || buzzer !== (e.st == 2'd1)) begin
        errors++;
        $display("FAIL disable[%0d]: got state=%0d missed=%b ringing=%b snoozing=%b buzzer=%b, expected state=%0d missed=%b",
                 i, state, missed, ringing, snoozing, buzzer, e.st, e.ms);
      end
    end
  endtask

  task automatic test_illegal();
    force dut.state_r = state_t'(2'd3);
    #1;
    checks++;
    if (state !== 2'd3 || ringing !== 1'b0 || snoozing !== 1'b0) begin
      errors++;
      $display("FAIL illegal_forced: got state=%0d ringing=%b snoozing=%b, expected state=3 ringing=0 snoozing=0",
               state, ringing, snoozing);
    end
    release dut.state_r;
    step(mk(0, 7, 0, 0, 0, 0));
    checks++;
    if (state !== 2'd0) begin
      errors++;
      $display("FAIL illegal_recover: got state=%0d, expected 0", state);
    end
  endtask

  task automatic test_sweep();
    logic [4:0] ah_tab[4] = '{5'd0, 5'd23, 5'd7, 5'd24};
    logic [5:0] am_tab[4] = '{6'd0, 6'd59, 6'd30, 6'd30};
    int         rings;
    int         want;
    for (int a = 0; a < 4; a++) begin
      ring_sb.push_back((ah_tab[a] == 5'd24) ? 0 : 1);
      bus.alarm_hours = ah_tab[a]; bus.alarm_minutes = am_tab[a];
      rings = 0;
      for (int h = 0; h < 24; h++) begin
        for (int m = 0; m < 60; m++) begin
          tick_at(h, m, 0);
          if (ringing === 1'b1) begin
            rings++;
            dismiss = 1'b1; @(posedge clk); #1; dismiss = 1'b0;
          end
          tick_at(h, m, 30);
          if (ringing === 1'b1) begin
            rings++;
            dismiss = 1'b1; @(posedge clk); #1; dismiss = 1'b0;
          end
        end
      end
      want = ring_sb.pop_front();
      checks++;
      if (rings !== want) begin
        errors++;
        $display("FAIL sweep[%0d:%0d]: got %0d ring starts, expected %0d", ah_tab[a], am_tab[a], rings, want);
      end
    end
  endtask

  initial begin
    bus.tick_1hz = 1'b0;
    bus.cur_hours = 5'd0; bus.cur_minutes = 6'd0; bus.cur_seconds = 6'd0;
    bus.alarm_hours = 5'd7; bus.alarm_minutes = 6'd30;
    @(negedge clk);
    test_reset();
    test_match();
    test_timeout();
    test_snooze();
    test_back_to_back();
    test_disable();
    test_illegal();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
